pb_debounce: RTL and testbench

Pushbutton conditioner for the robot's "go" and mode buttons. It sits directly downstream of the reset synchronizer and runs on the same clock and reset domain. It synchronizes a raw, bouncing, active-low button input and filters it with a stable-count debouncer. It outputs a clean level plus single-cycle press, release and long-press pulses for the command/control FSM.

---
 rtl/pb_debounce_if.sv | 30 +++
 rtl/pb_debounce.sv | 134 +++++++++++++
 tb/tb_pb_debounce.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pb_debounce_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : pb_debounce_if
// Purpose  : Raw pushbutton input and conditioned level/pulse outputs.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
interface pb_debounce_if;
  logic PB;
  logic pb_level;
  logic pb_press;
  logic pb_release;
  logic pb_long;

  modport master (
    output PB,
    input  pb_level,
    input  pb_press,
    input  pb_release,
    input  pb_long
  );

  modport slave (
    input  PB,
    output pb_level,
    output pb_press,
    output pb_release,
    output pb_long
  );
endinterface
`default_nettype wire

// File: rtl/pb_debounce.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : pb_debounce
// Purpose  : Synchronizes and debounces an active-low pushbutton, producing a
//            clean level plus press, release and long-press pulses.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module pb_debounce #(
  parameter int DB_CYC   = 50000,
  parameter int LONG_CYC = 50000000,
  parameter int CNT_W    = 16,
  parameter int LCNT_W   = 26
) (
  input  wire logic    clk,
  input  wire logic    RST_n,
  pb_debounce_if.slave pb_if
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_WAIT = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_REL_WAIT   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  c_DB_LAST   = CNT_W'(DB_CYC - 1);
  localparam logic [LCNT_W-1:0] c_LONG      = LCNT_W'(LONG_CYC);
  localparam logic [LCNT_W-1:0] c_LONG_LAST = LCNT_W'(LONG_CYC - 1);

  state_t              r_state;
  logic                r_ff1;
  logic                r_ff2;
  logic [CNT_W-1:0]    r_cnt;
  logic [LCNT_W-1:0]   r_lcnt;
  logic                r_level;
  logic                r_press;
  logic                r_release;
  logic                r_long;

  logic                w_s;
  logic                w_press_acc;
  logic                w_rel_acc;

  assign w_s         = ~r_ff2;
  assign w_press_acc = (r_state == ST_PRESS_WAIT) &&  w_s && (r_cnt == c_DB_LAST);
  assign w_rel_acc   = (r_state == ST_REL_WAIT)   && !w_s && (r_cnt == c_DB_LAST);

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      r_ff1     <= 1'b1;
      r_ff2     <= 1'b1;
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_lcnt    <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
    end else begin
      r_ff1     <= pb_if.PB;
      r_ff2     <= r_ff1;
      r_press   <= 1'b0;
      r_release <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_s) begin
            r_state <= ST_PRESS_WAIT;
            r_cnt   <= CNT_W'(1);
          end else begin
            r_cnt   <= '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!w_s) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (w_press_acc) begin
            r_state <= ST_PRESSED;
            r_level <= 1'b1;
            r_press <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!w_s) begin
            r_state <= ST_REL_WAIT;
            r_cnt   <= CNT_W'(1);
          end else begin
            r_cnt   <= '0;
          end
        end
        ST_REL_WAIT: begin
          if (w_s) begin
            r_state   <= ST_PRESSED;
            r_cnt     <= '0;
          end else if (w_rel_acc) begin
            r_state   <= ST_IDLE;
            r_level   <= 1'b0;
            r_release <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt     <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase

      // Only an accepted press restarts the hold timer; an aborted release
      // returns to PRESSED without touching it.
      if (w_press_acc) begin
        r_lcnt <= '0;
      end else if (r_level && (r_lcnt != c_LONG)) begin
        r_lcnt <= r_lcnt + 1'b1;
      end

      // Suppressed when the release is accepted on the same edge so the long
      // pulse never overlaps a falling level.
      r_long <= r_level && (r_lcnt == c_LONG_LAST) && !w_rel_acc;
    end
  end

  assign pb_if.pb_level   = r_level;
  assign pb_if.pb_press   = r_press;
  assign pb_if.pb_release = r_release;
  assign pb_if.pb_long    = r_long;

endmodule
`default_nettype wire

// File: tb/tb_pb_debounce.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_pb_debounce
// Purpose  : Directed self-checking bench for pb_debounce (DB_CYC=4, LONG_CYC=10).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_pb_debounce;

  localparam int DB_CYC   = 4;
  localparam int LONG_CYC = 10;

  logic clk;
  logic RST_n;
  int   n_checks;
  int   n_err;
  int   n_press;
  int   n_release;
  int   n_long;
  int   n_viol;
  int   base_p;
  int   base_r;
  int   base_l;

  pb_debounce_if bus ();

  pb_debounce #(
    .DB_CYC   (DB_CYC),
    .LONG_CYC (LONG_CYC),
    .CNT_W    (16),
    .LCNT_W   (26)
  ) u_dut (
    .clk   (clk),
    .RST_n (RST_n),
    .pb_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tallies and exclusivity watch, sampled mid-cycle.
  initial begin
    n_press = 0; n_release = 0; n_long = 0; n_viol = 0;
  end
  always @(negedge clk) begin
    if (bus.pb_press)   n_press++;
    if (bus.pb_release) n_release++;
    if (bus.pb_long)    n_long++;
    if (bus.pb_press && bus.pb_release) n_viol++;
    if (bus.pb_long && (bus.pb_press || bus.pb_release || !bus.pb_level)) n_viol++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all0(input string tag);
    chk({tag, "_level"},   int'(bus.pb_level),   0);
    chk({tag, "_press"},   int'(bus.pb_press),   0);
    chk({tag, "_release"}, int'(bus.pb_release), 0);
    chk({tag, "_long"},    int'(bus.pb_long),    0);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    RST_n    = 1'b0;
    bus.PB   = 1'b0;

    // Reset hold with button pressed; first edge after release is E0.
    #32;
    chk_all0("rst_hold");
    @(posedge clk); #1;
    RST_n = 1'b1;
    tick(5);
    chk("rst_rel_e4_press", int'(bus.pb_press), 0);
    chk("rst_rel_e4_level", int'(bus.pb_level), 0);
    tick(1);
    chk("rst_rel_e5_press", int'(bus.pb_press), 1);
    chk("rst_rel_e5_level", int'(bus.pb_level), 1);
    tick(1);
    chk("rst_rel_e6_press", int'(bus.pb_press), 0);

    // Release from that press.
    bus.PB = 1'b1;
    tick(5);
    chk("rel1_e4_release", int'(bus.pb_release), 0);
    chk("rel1_e4_level",   int'(bus.pb_level),   1);
    tick(1);
    chk("rel1_e5_release", int'(bus.pb_release), 1);
    chk("rel1_e5_level",   int'(bus.pb_level),   0);
    tick(1);
    chk("rel1_e6_release", int'(bus.pb_release), 0);

    // Clean press / release.
    tick(3);
    bus.PB = 1'b0;
    tick(5);
    chk("clean_e4_press", int'(bus.pb_press), 0);
    tick(1);
    chk("clean_e5_press", int'(bus.pb_press), 1);
    chk("clean_e5_level", int'(bus.pb_level), 1);
    tick(1);
    chk("clean_e6_press", int'(bus.pb_press), 0);
    chk("clean_e6_level", int'(bus.pb_level), 1);
    bus.PB = 1'b1;
    tick(5);
    chk("clean_rel_e4", int'(bus.pb_release), 0);
    tick(1);
    chk("clean_rel_e5", int'(bus.pb_release), 1);
    tick(1);
    chk("clean_rel_e6", int'(bus.pb_release), 0);
    chk("clean_rel_level", int'(bus.pb_level), 0);

    // Bounce: 2-cycle toggles never reach DB_CYC samples.
    tick(3);
    base_p = n_press; base_r = n_release; base_l = n_long;
    for (int i = 0; i < 10; i++) begin
      bus.PB = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(2);
    end
    chk("bounce_no_level", int'(bus.pb_level), 0);
    bus.PB = 1'b0;
    tick(5);
    chk("bounce_e4_press", int'(bus.pb_press), 0);
    tick(1);
    chk("bounce_e5_press", int'(bus.pb_press), 1);
    tick(1);
    chk("bounce_press_cnt",   n_press - base_p,   1);
    chk("bounce_release_cnt", n_release - base_r, 0);

    // Long press: level rose at L=E5, now at L+1.
    tick(8);
    chk("long_l9", int'(bus.pb_long), 0);
    tick(1);
    chk("long_l10",       int'(bus.pb_long),  1);
    chk("long_l10_level", int'(bus.pb_level), 1);
    tick(1);
    chk("long_l11", int'(bus.pb_long), 0);
    tick(29);
    chk("long_once", n_long - base_l, 1);

    // Release then second press gives a second long pulse.
    bus.PB = 1'b1;
    tick(6);
    chk("long_rel_level", int'(bus.pb_level), 0);
    tick(2);
    bus.PB = 1'b0;
    tick(6);
    chk("long2_level", int'(bus.pb_level), 1);
    tick(9);
    chk("long2_l9", int'(bus.pb_long), 0);
    tick(1);
    chk("long2_l10", int'(bus.pb_long), 1);
    tick(5);
    chk("long_twice", n_long - base_l, 2);

    // Release glitch of 3 cycles: no release, long timing unchanged.
    bus.PB = 1'b1;
    tick(8);
    tick(2);
    bus.PB = 1'b0;
    tick(6);
    base_r = n_release;
    tick(1);
    bus.PB = 1'b1;
    tick(3);
    bus.PB = 1'b0;
    tick(5);
    chk("glitch_level",   int'(bus.pb_level), 1);
    chk("glitch_l9_long", int'(bus.pb_long),  0);
    tick(1);
    chk("glitch_l10_long", int'(bus.pb_long), 1);
    chk("glitch_no_rel",   n_release - base_r, 0);

    // Mid-operation reset during PRESS_WAIT (cnt=2 after E3).
    bus.PB = 1'b1;
    tick(10);
    bus.PB = 1'b0;
    tick(4);
    #2;
    RST_n = 1'b0;
    #1;
    chk_all0("rst_wait");
    @(posedge clk); #1;
    RST_n = 1'b1;
    tick(5);
    chk("rst_wait_e4_press", int'(bus.pb_press), 0);
    tick(1);
    chk("rst_wait_e5_press", int'(bus.pb_press), 1);

    // Reset in the middle of the press pulse.
    #2;
    RST_n = 1'b0;
    #1;
    chk_all0("rst_pulse");
    @(posedge clk); #1;
    RST_n = 1'b1;
    tick(5);
    chk("rst_pulse_e4_press", int'(bus.pb_press), 0);
    chk("rst_pulse_e4_level", int'(bus.pb_level), 0);
    tick(1);
    chk("rst_pulse_e5_press", int'(bus.pb_press), 1);
    tick(1);

    chk("exclusive_pulses", n_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
